vga_mode_ctrl: RTL and testbench

Display-mode scheduler for the picture datapath. Debounces the four board push-buttons, latches mode requests and applies them only at frame boundaries so a frame is never rendered in mixed modes. Sequences the edge pipeline: an edge-display request first runs a fill pass, during which the Sobel results are written to the edge RAM, before the edge image is shown. Its `mode` output drives the datapath's 4-bit key/mode input directly.

---
 rtl/vga_mode_ctrl_if.sv | 21 ++
 rtl/vga_mode_ctrl.sv | 155 +++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_mode_ctrl_if.sv
// Signal bundle between the board keys, the picture datapath and the display-mode scheduler.
// The scheduler uses the slave modport; whatever drives keys, pixel position and Sobel strobes uses master.
interface vga_mode_ctrl_if;
    logic [3:0] key_raw;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       sobel_valid;
    logic [3:0] mode;
    logic       edge_ready;
    logic       busy;

    modport master (
        output key_raw, pix_x, pix_y, sobel_valid,
        input  mode, edge_ready, busy
    );

    modport slave (
        input  key_raw, pix_x, pix_y, sobel_valid,
        output mode, edge_ready, busy
    );
endinterface

// File: rtl/vga_mode_ctrl.sv
// Display-mode scheduler: debounced key presses become mode changes applied only at frame start.
// Define VGA_MODE_CTRL_DEBOUNCE_EN to include the per-key debounce counters.
module vga_mode_ctrl #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int HOR_PIC     = 160,
    parameter int VERT_PIC    = 160,
    parameter int EDGE_PIXELS = (HOR_PIC - 2) * (VERT_PIC - 2)
) (
    input  logic           clk,
    input  logic           rst,
    vga_mode_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_OFF, S_COLOR, S_GRAY, S_FILL, S_SHOW} state_t;

    localparam logic [1:0]  REQ_COLOR  = 2'd0;
    localparam logic [1:0]  REQ_GRAY   = 2'd1;
    localparam logic [1:0]  REQ_EDGE   = 2'd2;
    localparam logic [1:0]  REQ_OFF    = 2'd3;
    localparam logic [3:0]  MODE_OFF   = 4'b0000;
    localparam logic [3:0]  MODE_COLOR = 4'b0001;
    localparam logic [3:0]  MODE_GRAY  = 4'b0010;
    localparam logic [3:0]  MODE_EDGE  = 4'b0100;
    localparam logic [15:0] FILL_MAX   = 16'(EDGE_PIXELS);

    state_t      state;
    logic [3:0]  sync1, sync2, key_sync;
    logic [3:0]  deb_level, deb_prev, press;
    logic        press_any, frame_start, req_pend;
    logic [1:0]  press_code, req_code;
    logic [15:0] fill_cnt;
    logic [3:0]  mode_r;
    logic        busy_r, ready_r;

    // Keys are active-low and asynchronous; synchronizers idle at the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= bus.key_raw;
            sync2 <= sync1;
        end
    end

    assign key_sync = ~sync2;

`ifdef VGA_MODE_CTRL_DEBOUNCE_EN
    localparam int            CW      = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic [CW-1:0] deb_cnt [4];

    // A key level is accepted only after it has disagreed with the debounced level for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
            deb_level <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_sync[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_MAX) begin
                    deb_level[i] <= key_sync[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) deb_level <= '0;
        else     deb_level <= key_sync;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) deb_prev <= '0;
        else     deb_prev <= deb_level;
    end

    assign press       = deb_level & ~deb_prev;
    assign frame_start = (bus.pix_x == 10'd0) && (bus.pix_y == 10'd0);

    // Lowest-numbered key wins when several presses land in the same cycle.
    always_comb begin
        press_any  = |press;
        press_code = REQ_OFF;
        if (press[0])      press_code = REQ_COLOR;
        else if (press[1]) press_code = REQ_GRAY;
        else if (press[2]) press_code = REQ_EDGE;
    end

    // Mode changes happen only on the frame_start edge so a frame never mixes modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OFF;
            mode_r   <= MODE_OFF;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            req_pend <= 1'b0;
            req_code <= REQ_OFF;
            fill_cnt <= '0;
        end else begin
            if (press_any) begin
                req_pend <= 1'b1;
                req_code <= press_code;
            end else if (frame_start) begin
                req_pend <= 1'b0;
            end

            if (state == S_FILL && bus.sobel_valid && fill_cnt != FILL_MAX)
                fill_cnt <= fill_cnt + 16'd1;
            if (state == S_FILL && fill_cnt == FILL_MAX)
                ready_r <= 1'b1;

            if (frame_start) begin
                if (req_pend && req_code != REQ_EDGE) begin
                    fill_cnt <= '0;
                    busy_r   <= 1'b0;
                    case (req_code)
                        REQ_COLOR: begin state <= S_COLOR; mode_r <= MODE_COLOR; end
                        REQ_GRAY:  begin state <= S_GRAY;  mode_r <= MODE_GRAY;  end
                        default: begin
                            state   <= S_OFF;
                            mode_r  <= MODE_OFF;
                            ready_r <= 1'b0;
                        end
                    endcase
                end else if (req_pend && state != S_FILL && state != S_SHOW) begin
                    if (ready_r) begin
                        state  <= S_SHOW;
                        mode_r <= MODE_EDGE;
                        busy_r <= 1'b0;
                    end else begin
                        // FILL shows gray because the datapath only writes the edge RAM in colour/gray modes.
                        state    <= S_FILL;
                        mode_r   <= MODE_GRAY;
                        busy_r   <= 1'b1;
                        fill_cnt <= '0;
                    end
                end else if (state == S_FILL && ready_r) begin
                    state  <= S_SHOW;
                    mode_r <= MODE_EDGE;
                    busy_r <= 1'b0;
                end
            end
        end
    end

    assign bus.mode       = mode_r;
    assign bus.busy       = busy_r;
    assign bus.edge_ready = ready_r;
endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed and randomized bench for vga_mode_ctrl, checked against a per-operation behavioural model.
`timescale 1ns/1ps
module tb_vga_mode_ctrl;
    localparam int DEB      = 4;
    localparam int EDGE_PIX = 16;
`ifdef VGA_MODE_CTRL_DEBOUNCE_EN
    localparam int LAT      = 3 + DEB;
    localparam bit DEBOUNCE = 1'b1;
`else
    localparam int LAT      = 3;
    localparam bit DEBOUNCE = 1'b0;
`endif
    localparam logic [3:0] M_OFF   = 4'b0000;
    localparam logic [3:0] M_COLOR = 4'b0001;
    localparam logic [3:0] M_GRAY  = 4'b0010;
    localparam logic [3:0] M_EDGE  = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vga_mode_ctrl_if bus ();

    vga_mode_ctrl #(
        .DEB_CYCLES  (DEB),
        .HOR_PIC     (160),
        .VERT_PIC    (160),
        .EDGE_PIXELS (EDGE_PIX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [3:0] m_mode;
    bit         m_busy, m_ready, m_pend;
    int         m_req, m_count;

    task automatic model_reset();
        m_mode = M_OFF; m_busy = 0; m_ready = 0; m_pend = 0; m_req = 0; m_count = 0;
    endtask

    task automatic model_press(input logic [3:0] mask);
        for (int i = 3; i >= 0; i--) if (mask[i]) m_req = i;
        m_pend = 1;
    endtask

    // Key meaning: 0 colour, 1 gray, 2 edge, 3 off; a finished fill turns into the edge display.
    task automatic model_frame();
        if (m_pend) begin
            m_pend = 0;
            case (m_req)
                0: begin m_mode = M_COLOR; m_busy = 0; m_count = 0; end
                1: begin m_mode = M_GRAY;  m_busy = 0; m_count = 0; end
                3: begin m_mode = M_OFF;   m_busy = 0; m_count = 0; m_ready = 0; end
                default: begin
                    if (!m_busy && m_mode != M_EDGE) begin
                        if (m_ready) m_mode = M_EDGE;
                        else begin m_mode = M_GRAY; m_busy = 1; m_count = 0; end
                    end
                end
            endcase
        end
        if (m_busy && m_ready) begin
            m_mode = M_EDGE;
            m_busy = 0;
        end
    endtask

    task automatic model_sobel(input int n);
        if (m_busy) begin
            m_count = (m_count + n > EDGE_PIX) ? EDGE_PIX : m_count + n;
            if (m_count == EDGE_PIX) m_ready = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.pix_x = 10'($urandom_range(0, 159));
        bus.pix_y = 10'($urandom_range(1, 159));
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_mode,
                               input logic exp_busy, input logic exp_ready);
        n_compared++;
        assert (bus.mode === exp_mode) else begin
            n_mismatched++;
            $error("[TB] FAIL %s mode: observed %b expected %b", tag, bus.mode, exp_mode);
        end
        n_compared++;
        assert (bus.busy === exp_busy) else begin
            n_mismatched++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, bus.busy, exp_busy);
        end
        n_compared++;
        assert (bus.edge_ready === exp_ready) else begin
            n_mismatched++;
            $error("[TB] FAIL %s edge_ready: observed %b expected %b", tag, bus.edge_ready, exp_ready);
        end
    endtask

    task automatic check_model(input string tag);
        checkOutput(tag, m_mode, m_busy, m_ready);
    endtask

    // Clean press: hold long enough for either build, then release and let the level settle.
    task automatic applyStimulus(input logic [3:0] mask);
        bus.key_raw = ~mask;
        repeat (12) tick();
        bus.key_raw = 4'hF;
        repeat (14) tick();
        model_press(mask);
    endtask

    task automatic frame_pulse();
        bus.pix_x = 10'd0;
        bus.pix_y = 10'd0;
        tick();
    endtask

    task automatic frame_and_check(input string tag);
        frame_pulse();
        model_frame();
        check_model(tag);
    endtask

    task automatic sobel_burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sobel_valid = 1'b1;
            tick();
            bus.sobel_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (2) tick();
        model_sobel(n);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.key_raw     = 4'hF;
        bus.sobel_valid = 1'b0;
        bus.pix_x       = 10'd5;
        bus.pix_y       = 10'd5;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_model("reset_initial");

        applyStimulus(4'b0001);
        frame_and_check("color");
        applyStimulus(4'b0100);
        frame_and_check("fill_enter");
        sobel_burst(6);

        // Reset asserted mid-run for three cycles, including mid-fill.
        rst = 1'b1;
        tick();
        model_reset();
        check_model("reset_first_edge");
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check_model("reset_held");
        frame_and_check("reset_no_request");

        applyStimulus(4'b0001);
        check_model("color_pending_midframe");
        frame_and_check("color_at_frame");
        applyStimulus(4'b0010);
        frame_and_check("gray_at_frame");

        applyStimulus(4'b0100);
        frame_and_check("fill_from_gray");
        sobel_burst(EDGE_PIX);
        check_model("fill_complete_ready");
        frame_and_check("show_after_fill");

        applyStimulus(4'b1000);
        frame_and_check("off_clears_ready");
        applyStimulus(4'b0100);
        frame_and_check("edge_after_off_fills");
        sobel_burst(10);
        check_model("fill_partial");
        applyStimulus(4'b0001);
        frame_and_check("abort_fill_color");
        applyStimulus(4'b0100);
        frame_and_check("refill_enter");
        sobel_burst(EDGE_PIX - 1);
        check_model("refill_restarted_at_zero");

        // Final Sobel strobe shares the frame_start cycle.
        bus.sobel_valid = 1'b1;
        frame_pulse();
        bus.sobel_valid = 1'b0;
        model_frame();
        check_model("last_pulse_at_frame");
        tick();
        model_sobel(1);
        check_model("ready_cycle_after");
        frame_and_check("show_after_late_pulse");

        applyStimulus(4'b0010);
        frame_and_check("gray_before_bounce");
        for (int i = 0; i < 5; i++) begin
            bus.key_raw[0] = 1'b0;
            repeat (2) tick();
            bus.key_raw[0] = 1'b1;
            repeat (2) tick();
        end
        repeat (14) tick();
        if (!DEBOUNCE) model_press(4'b0001);
        frame_and_check("bounce");
        applyStimulus(4'b1010);
        frame_and_check("priority_key1_over_key3");
        applyStimulus(4'b0010);
        frame_and_check("gray_before_latency");

        // Press arriving exactly in the frame_start cycle is only latched.
        bus.key_raw = 4'b1110;
        repeat (LAT) tick();
        frame_pulse();
        model_frame();
        check_model("press_on_frame_latched");
        model_press(4'b0001);
        bus.key_raw = 4'hF;
        repeat (14) tick();
        frame_and_check("latched_press_applied");
        bus.key_raw = 4'b1101;
        repeat (LAT + 1) tick();
        model_press(4'b0010);
        frame_and_check("press_one_cycle_before_frame");
        bus.key_raw = 4'hF;
        repeat (14) tick();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       applyStimulus(4'($urandom_range(1, 15)));
                1:       sobel_burst($urandom_range(0, 20));
                default: frame_and_check("rand_frame");
            endcase
            check_model("rand_step");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
